// File: rtl/max7219_sequencer.sv
// MAX7219 frame sequencer: five-frame configuration after reset, then six digit
// writes per refresh. Frames go to the SPI engine over a valid/ready handshake.
module max7219_sequencer #(
    parameter logic [3:0] INTENSITY  = 4'h8,
    parameter logic [2:0] SCAN_LIMIT = 3'd5
) (
    input  logic        clk,
    input  logic        res,
    input  logic        ena,
    input  logic        refresh,
    input  logic [2:0]  min_X0,
    input  logic [3:0]  min_0X,
    input  logic [2:0]  sec_X0,
    input  logic [3:0]  sec_0X,
    input  logic [3:0]  ces_X0,
    input  logic [3:0]  ces_0X,
    output logic [15:0] frame,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        busy,
    output logic        init_done
);

    typedef enum logic [1:0] {StInit, StIdle, StUpdate} state_e;

    localparam logic [2:0] InitLast   = 3'd4;
    localparam logic [2:0] UpdateLast = 3'd5;

    state_e      state;
    logic [2:0]  index;
    logic        pending;
    logic [23:0] snap;

    logic [23:0] live;
    logic        accept;
    logic        last;
    logic        req;
    logic        serve;

    // Digit nibbles packed in frame order: index i lives at bits [4i+3:4i].
    assign live = {1'b0, min_X0, min_0X, 1'b0, sec_X0, sec_0X, ces_X0, ces_0X};

    assign accept = frame_valid && frame_ready;
    assign last   = accept && (((state == StInit) && (index == InitLast)) ||
                               ((state == StUpdate) && (index == UpdateLast)));
    assign req    = refresh && ena;
    // A request arriving on the final acceptance is served like a stored one.
    assign serve  = pending || req;

    function automatic logic [15:0] init_frame(input logic [2:0] idx);
        logic [15:0] f;
        case (idx)
            3'd0:    f = 16'h0F00;
            3'd1:    f = 16'h09FF;
            3'd2:    f = {8'h0A, 4'h0, INTENSITY};
            3'd3:    f = {8'h0B, 5'b00000, SCAN_LIMIT};
            default: f = 16'h0C01;
        endcase
        return f;
    endfunction

    function automatic logic [15:0] upd_frame(input logic [2:0] idx, input logic [23:0] d);
        logic [3:0] addr;
        logic [3:0] digit;
        logic       dp;
        addr  = {1'b0, idx} + 4'd1;
        digit = d[{idx, 2'b00} +: 4];
        dp    = (idx == 3'd2) || (idx == 3'd4);
        return {4'h0, addr, dp, 3'b000, digit};
    endfunction

    always_ff @(posedge clk) begin
        if (res) begin
            state       <= StInit;
            index       <= 3'd0;
            pending     <= 1'b0;
            snap        <= 24'h0;
            frame       <= 16'h0000;
            frame_valid <= 1'b0;
            busy        <= 1'b1;
            init_done   <= 1'b0;
        end else if (last) begin
            if (state == StInit) begin
                init_done <= 1'b1;
            end
            if (serve) begin
                pending <= 1'b0;
                snap    <= live;
                state   <= StUpdate;
                index   <= 3'd0;
                frame   <= upd_frame(3'd0, live);
            end else begin
                state       <= StIdle;
                index       <= 3'd0;
                frame_valid <= 1'b0;
                busy        <= 1'b0;
            end
        end else begin
            if (req && (state != StIdle)) begin
                pending <= 1'b1;
            end
            unique case (state)
                StInit: begin
                    if (!frame_valid) begin
                        frame       <= init_frame(index);
                        frame_valid <= 1'b1;
                    end else if (accept) begin
                        index <= index + 3'd1;
                        frame <= init_frame(index + 3'd1);
                    end
                end
                StIdle: begin
                    if (req) begin
                        snap        <= live;
                        state       <= StUpdate;
                        index       <= 3'd0;
                        frame       <= upd_frame(3'd0, live);
                        frame_valid <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                StUpdate: begin
                    if (accept) begin
                        index <= index + 3'd1;
                        frame <= upd_frame(index + 3'd1, snap);
                    end
                end
                default: ;
            endcase
        end
    end

    a_hold_stable: assert property (@(posedge clk) disable iff (res)
        (frame_valid && !frame_ready) |=> (frame_valid && $stable(frame)));

    a_busy_state: assert property (@(posedge clk) disable iff (res)
        busy == (state != StIdle));

endmodule

// File: tb/tb_max7219_sequencer.sv
// Directed bench for max7219_sequencer: init sequence, updates, stall,
// pending collapse, ena gating and mid-update reset.
module tb_max7219_sequencer;

    logic        clk = 1'b0;
    logic        res;
    logic        ena;
    logic        refresh;
    logic [2:0]  min_X0;
    logic [3:0]  min_0X;
    logic [2:0]  sec_X0;
    logic [3:0]  sec_0X;
    logic [3:0]  ces_X0;
    logic [3:0]  ces_0X;
    logic [15:0] frame;
    logic        frame_valid;
    logic        frame_ready;
    logic        busy;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    max7219_sequencer dut (
        .clk         (clk),
        .res         (res),
        .ena         (ena),
        .refresh     (refresh),
        .min_X0      (min_X0),
        .min_0X      (min_0X),
        .sec_X0      (sec_X0),
        .sec_0X      (sec_0X),
        .ces_X0      (ces_X0),
        .ces_0X      (ces_0X),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy),
        .init_done   (init_done)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_frame(input string tag, input logic [15:0] exp);
        step();
        check({tag, "_valid"}, {15'h0, frame_valid}, 16'h1);
        check(tag, frame, exp);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, {15'h0, frame_valid}, 16'h0);
        check({tag, "_busy"}, {15'h0, busy}, 16'h0);
    endtask

    task automatic set_digits(input logic [2:0] mt, input logic [3:0] mu, input logic [2:0] st,
                              input logic [3:0] su, input logic [3:0] ct, input logic [3:0] cu);
        min_X0 = mt; min_0X = mu; sec_X0 = st; sec_0X = su; ces_X0 = ct; ces_0X = cu;
    endtask

    task automatic expect_init(input string tag);
        expect_frame({tag, "_f0"}, 16'h0F00);
        expect_frame({tag, "_f1"}, 16'h09FF);
        expect_frame({tag, "_f2"}, 16'h0A08);
        expect_frame({tag, "_f3"}, 16'h0B05);
        expect_frame({tag, "_f4"}, 16'h0C01);
    endtask

    initial begin
        res = 1'b1; ena = 1'b1; refresh = 1'b0; frame_ready = 1'b1;
        set_digits(3'd0, 4'd0, 3'd0, 4'd0, 4'd0, 4'd0);
        step(); step();
        check("rst_frame", frame, 16'h0000);
        check("rst_valid", {15'h0, frame_valid}, 16'h0);
        check("rst_busy", {15'h0, busy}, 16'h1);
        check("rst_init_done", {15'h0, init_done}, 16'h0);
        res = 1'b0;

        // Configuration sequence
        expect_init("init");
        step();
        expect_idle("init_end");
        check("init_done", {15'h0, init_done}, 16'h1);

        // Single update with digits 5,9,3,7,4,2
        set_digits(3'd5, 4'd9, 3'd3, 4'd7, 4'd4, 4'd2);
        refresh = 1'b1;
        expect_frame("upd_f0", 16'h0102);
        refresh = 1'b0;
        expect_frame("upd_f1", 16'h0204);
        expect_frame("upd_f2", 16'h0387);
        expect_frame("upd_f3", 16'h0403);
        expect_frame("upd_f4", 16'h0589);
        expect_frame("upd_f5", 16'h0605);
        step();
        expect_idle("upd_end");

        // Stall on frame 3 for 10 cycles
        refresh = 1'b1;
        expect_frame("stl_f0", 16'h0102);
        refresh = 1'b0;
        expect_frame("stl_f1", 16'h0204);
        expect_frame("stl_f2", 16'h0387);
        frame_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            expect_frame("stl_hold", 16'h0387);
        end
        frame_ready = 1'b1;
        expect_frame("stl_f3", 16'h0403);
        expect_frame("stl_f4", 16'h0589);
        expect_frame("stl_f5", 16'h0605);
        step();
        expect_idle("stl_end");

        // Input changes and collapsed refreshes during an update
        refresh = 1'b1;
        expect_frame("pnd_f0", 16'h0102);
        set_digits(3'd0, 4'd0, 3'd0, 4'd0, 4'd0, 4'd0);
        expect_frame("pnd_f1", 16'h0204);
        refresh = 1'b0;
        expect_frame("pnd_f2", 16'h0387);
        refresh = 1'b1;
        expect_frame("pnd_f3", 16'h0403);
        refresh = 1'b0;
        expect_frame("pnd_f4", 16'h0589);
        refresh = 1'b1;
        expect_frame("pnd_f5", 16'h0605);
        refresh = 1'b0;
        expect_frame("pnd_g0", 16'h0100);
        expect_frame("pnd_g1", 16'h0200);
        expect_frame("pnd_g2", 16'h0380);
        expect_frame("pnd_g3", 16'h0400);
        expect_frame("pnd_g4", 16'h0580);
        expect_frame("pnd_g5", 16'h0600);
        step();
        expect_idle("pnd_end");

        // Refresh coinciding with the final acceptance chains straight on
        refresh = 1'b1;
        expect_frame("chn_f0", 16'h0100);
        refresh = 1'b0;
        set_digits(3'd1, 4'd2, 3'd3, 4'd4, 4'd5, 4'd6);
        expect_frame("chn_f1", 16'h0200);
        expect_frame("chn_f2", 16'h0380);
        expect_frame("chn_f3", 16'h0400);
        expect_frame("chn_f4", 16'h0580);
        expect_frame("chn_f5", 16'h0600);
        refresh = 1'b1;
        expect_frame("chn_g0", 16'h0106);
        refresh = 1'b0;
        expect_frame("chn_g1", 16'h0205);
        expect_frame("chn_g2", 16'h0384);
        expect_frame("chn_g3", 16'h0403);
        expect_frame("chn_g4", 16'h0582);
        expect_frame("chn_g5", 16'h0601);
        step();
        expect_idle("chn_end");

        // ena low blocks refreshes in IDLE
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            refresh = 1'b1;
            step();
            refresh = 1'b0;
            step();
            expect_idle("ena_off");
        end
        ena = 1'b1;

        // Reset during update frame 4 discards pending and restarts INIT
        refresh = 1'b1;
        expect_frame("rsu_f0", 16'h0106);
        refresh = 1'b0;
        expect_frame("rsu_f1", 16'h0205);
        refresh = 1'b1;
        expect_frame("rsu_f2", 16'h0384);
        refresh = 1'b0;
        expect_frame("rsu_f3", 16'h0403);
        res = 1'b1;
        step();
        res = 1'b0;
        check("rsu_valid", {15'h0, frame_valid}, 16'h0);
        check("rsu_init_done", {15'h0, init_done}, 16'h0);
        check("rsu_busy", {15'h0, busy}, 16'h1);
        check("rsu_frame", frame, 16'h0000);
        expect_init("reinit");
        step();
        expect_idle("reinit_end");
        check("reinit_done", {15'h0, init_done}, 16'h1);
        step();
        expect_idle("reinit_quiet");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
